// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: forwarding selects, sequencer states and
// the opcode encodings the decoder agrees on.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_LW   = 5'h08;
  localparam logic [4:0] OP_SW   = 5'h09;
  localparam logic [4:0] OP_ACT  = 5'h10;
  localparam logic [4:0] OP_LD   = 5'h11;
  localparam logic [4:0] OP_RD   = 5'h12;
  localparam logic [4:0] OP_MAP  = 5'h13;
  localparam logic [4:0] OP_CORD = 5'h14;
  localparam logic [4:0] OP_KEY  = 5'h18;
  localparam logic [4:0] OP_HALT = 5'h1f;

  // The younger writer (EX/MEM) always wins over the older one.
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit) return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sprite_busy_tracker.sv
// Single-owner occupancy counter for the multi-cycle sprite unit.
module sprite_busy_tracker #(
  parameter int unsigned SPRITE_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic allow_i,
  output logic go_o,
  output logic busy_o
);

  localparam int unsigned CntW = $clog2(SPRITE_LAT + 1);
  // The issue cycle is the first busy cycle, so the next op may go SPRITE_LAT cycles later.
  localparam logic [CntW-1:0] ReloadVal = CntW'(SPRITE_LAT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign busy_o = (cnt_q != '0);
  assign go_o   = req_i & ~busy_o & allow_i;

  always_comb begin
    cnt_d = cnt_q;
    if (go_o) begin
      cnt_d = ReloadVal;
    end else if (busy_o) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-side pipeline sequencer: load-use and resource stalls, registered forwarding selects,
// sprite-unit arbitration and the halt-drain sequence.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned SPRITE_LAT = 4,
  parameter int unsigned REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reS,
  input  logic              reT,
  input  logic [REG_AW-1:0] regS_addr,
  input  logic [REG_AW-1:0] regT_addr,
  input  logic              use_dst_reg,
  input  logic              sprite_use_dst,
  input  logic              is_load,
  input  logic [REG_AW-1:0] dst_reg,
  input  logic              sprite_re,
  input  logic              sprite_we,
  input  logic              IOR,
  input  logic              io_ready,
  input  logic              hlt,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        fwdS_sel,
  output logic [1:0]        fwdT_sel,
  output logic              sprite_go,
  output logic              halted
);

  logic              ex_v_q, ex_v_d, ex_ld_q, ex_ld_d;
  logic [REG_AW-1:0] ex_dst_q, ex_dst_d;
  logic              mem_v_q;
  logic [REG_AW-1:0] mem_dst_q;
  fwd_sel_t          fwd_s_q, fwd_s_d, fwd_t_q, fwd_t_d;
  state_t            state_q, state_d;
  logic              halted_q;

  logic id_wr, hz, spr_req, spr_busy, spr_allow, stall_raw;

  assign id_wr   = (use_dst_reg | sprite_use_dst) & (dst_reg != '0);
  assign hz      = ex_v_q & ex_ld_q &
                   ((reS & (regS_addr == ex_dst_q)) | (reT & (regT_addr == ex_dst_q)));
  assign spr_req = sprite_re | sprite_we;

  assign stall_raw = (state_q != RUN) | hz | (spr_req & spr_busy) | (IOR & ~io_ready) | hlt;
  // flush wins: the ID op is thrown away, so there is nothing to hold.
  assign stall  = rst_n & stall_raw & ~flush;
  assign bubble = rst_n & (stall_raw | flush);

  assign spr_allow = rst_n & ~flush & (state_q == RUN);

  sprite_busy_tracker #(
    .SPRITE_LAT (SPRITE_LAT)
  ) u_sprite_busy_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (spr_req),
    .allow_i (spr_allow),
    .go_o    (sprite_go),
    .busy_o  (spr_busy)
  );

  always_comb begin
    ex_v_d   = id_wr & ~bubble;
    ex_ld_d  = (is_load | sprite_use_dst) & ~bubble;
    ex_dst_d = bubble ? '0 : dst_reg;

    fwd_s_d = FWD_RF;
    fwd_t_d = FWD_RF;
    if (!bubble) begin
      fwd_s_d = fwd_pick(ex_v_q & (regS_addr == ex_dst_q), mem_v_q & (regS_addr == mem_dst_q));
      fwd_t_d = fwd_pick(ex_v_q & (regT_addr == ex_dst_q), mem_v_q & (regT_addr == mem_dst_q));
    end

    state_d = state_q;
    unique case (state_q)
      RUN:     if (hlt && !flush) state_d = DRAIN;
      DRAIN:   if (!ex_v_q && !mem_v_q && !spr_busy) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v_q    <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_dst_q  <= '0;
      mem_v_q   <= 1'b0;
      mem_dst_q <= '0;
      fwd_s_q   <= FWD_RF;
      fwd_t_q   <= FWD_RF;
      state_q   <= RUN;
      halted_q  <= 1'b0;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_ld_q   <= ex_ld_d;
      ex_dst_q  <= ex_dst_d;
      mem_v_q   <= ex_v_q;
      mem_dst_q <= ex_dst_q;
      fwd_s_q   <= fwd_s_d;
      fwd_t_q   <= fwd_t_d;
      state_q   <= state_d;
      halted_q  <= (state_d == HALTED);
    end
  end

  assign fwdS_sel = fwd_s_q;
  assign fwdT_sel = fwd_t_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenario bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reS, reT, use_dst_reg, sprite_use_dst, is_load;
  logic [4:0] regS_addr, regT_addr, dst_reg;
  logic       sprite_re, sprite_we, IOR, io_ready, hlt, flush;
  logic       stall, bubble, sprite_go, halted;
  logic [1:0] fwdS_sel, fwdT_sel;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .SPRITE_LAT (4),
    .REG_AW     (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reS            (reS),
    .reT            (reT),
    .regS_addr      (regS_addr),
    .regT_addr      (regT_addr),
    .use_dst_reg    (use_dst_reg),
    .sprite_use_dst (sprite_use_dst),
    .is_load        (is_load),
    .dst_reg        (dst_reg),
    .sprite_re      (sprite_re),
    .sprite_we      (sprite_we),
    .IOR            (IOR),
    .io_ready       (io_ready),
    .hlt            (hlt),
    .flush          (flush),
    .stall          (stall),
    .bubble         (bubble),
    .fwdS_sel       (fwdS_sel),
    .fwdT_sel       (fwdT_sel),
    .sprite_go      (sprite_go),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_idle();
    reS = 0; reT = 0; regS_addr = 0; regT_addr = 0;
    use_dst_reg = 0; sprite_use_dst = 0; is_load = 0; dst_reg = 0;
    sprite_re = 0; sprite_we = 0; IOR = 0; io_ready = 0; hlt = 0; flush = 0;
  endtask

  task automatic idle(input int n);
    id_idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 0;
    id_idle();
    step(); step();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (bubble !== 1'b0) begin n_bad++; $display("FAIL reset_bubble: got %b want 0", bubble); end
    n_cmp++; if (fwdS_sel !== 2'd0 || fwdT_sel !== 2'd0) begin n_bad++;
      $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwdS_sel, fwdT_sel); end
    n_cmp++; if (sprite_go !== 1'b0 || halted !== 1'b0) begin n_bad++;
      $display("FAIL reset_go_halted: got %b/%b want 0/0", sprite_go, halted); end
    rst_n = 1;
    step();
  endtask

  // LW r3 ; ADD r4,r3,r5
  task automatic test_load_use();
    id_idle(); is_load = 1; use_dst_reg = 1; dst_reg = 3; reS = 1; regS_addr = 1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_lw_stall: got %b want 0", stall); end
    step();
    id_idle(); reS = 1; reT = 1; regS_addr = 3; regT_addr = 5; use_dst_reg = 1; dst_reg = 4; #1;
    n_cmp++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_bad++;
      $display("FAIL lu_hz: got stall=%b bubble=%b want 1/1", stall, bubble); end
    step();
    n_cmp++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_bad++;
      $display("FAIL lu_release: got stall=%b bubble=%b want 0/0", stall, bubble); end
    n_cmp++; if (fwdS_sel !== 2'd0) begin n_bad++; $display("FAIL lu_fwd_cleared: got %0d want 0", fwdS_sel); end
    step();
    n_cmp++; if (fwdS_sel !== 2'd2 || fwdT_sel !== 2'd0) begin n_bad++;
      $display("FAIL lu_fwd: got %0d/%0d want 2/0", fwdS_sel, fwdT_sel); end
    idle(6);
  endtask

  // ADD r3 ; SUB r6,r3,r3 ; ADD r0,r6 ; read r0 ; LW r0 ; read r0
  task automatic test_forward();
    id_idle(); use_dst_reg = 1; dst_reg = 3; step();
    id_idle(); reS = 1; reT = 1; regS_addr = 3; regT_addr = 3; use_dst_reg = 1; dst_reg = 6; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fw_nostall: got %b want 0", stall); end
    step();
    n_cmp++; if (fwdS_sel !== 2'd1 || fwdT_sel !== 2'd1) begin n_bad++;
      $display("FAIL fw_ex: got %0d/%0d want 1/1", fwdS_sel, fwdT_sel); end
    id_idle(); reS = 1; regS_addr = 6; use_dst_reg = 1; dst_reg = 0; step();
    n_cmp++; if (fwdS_sel !== 2'd1) begin n_bad++; $display("FAIL fw_ex2: got %0d want 1", fwdS_sel); end
    id_idle(); reS = 1; reT = 1; regS_addr = 0; regT_addr = 0; step();
    n_cmp++; if (fwdS_sel !== 2'd0 || fwdT_sel !== 2'd0) begin n_bad++;
      $display("FAIL fw_r0: got %0d/%0d want 0/0", fwdS_sel, fwdT_sel); end
    id_idle(); is_load = 1; use_dst_reg = 1; dst_reg = 0; step();
    id_idle(); reS = 1; regS_addr = 0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fw_r0_load: got %b want 0", stall); end
    idle(6);
  endtask

  task automatic test_sprite_b2b();
    id_idle(); sprite_we = 1; #1;
    n_cmp++; if (sprite_go !== 1'b1 || stall !== 1'b0) begin n_bad++;
      $display("FAIL sp_t0: got go=%b stall=%b want 1/0", sprite_go, stall); end
    for (int t = 1; t <= 3; t++) begin
      step();
      n_cmp++; if (sprite_go !== 1'b0 || stall !== 1'b1) begin n_bad++;
        $display("FAIL sp_t%0d: got go=%b stall=%b want 0/1", t, sprite_go, stall); end
    end
    step();
    n_cmp++; if (sprite_go !== 1'b1 || stall !== 1'b0) begin n_bad++;
      $display("FAIL sp_t4: got go=%b stall=%b want 1/0", sprite_go, stall); end
    idle(6);
  endtask

  task automatic test_io_wait();
    id_idle(); IOR = 1; io_ready = 0; use_dst_reg = 1; dst_reg = 7;
    for (int t = 0; t < 3; t++) begin
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL io_wait%0d: got %b want 1", t, stall); end
      step();
    end
    io_ready = 1; #1;
    n_cmp++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_bad++;
      $display("FAIL io_issue: got stall=%b bubble=%b want 0/0", stall, bubble); end
    step();
    id_idle(); reS = 1; regS_addr = 7; step();
    n_cmp++; if (fwdS_sel !== 2'd1) begin n_bad++; $display("FAIL io_fwd: got %0d want 1", fwdS_sel); end
    idle(6);
  endtask

  task automatic test_flush();
    id_idle(); is_load = 1; use_dst_reg = 1; dst_reg = 3; step();
    id_idle(); reS = 1; regS_addr = 3; use_dst_reg = 1; dst_reg = 4; sprite_re = 1; flush = 1; #1;
    n_cmp++; if (stall !== 1'b0 || bubble !== 1'b1 || sprite_go !== 1'b0) begin n_bad++;
      $display("FAIL fl_ovr: got stall=%b bubble=%b go=%b want 0/1/0", stall, bubble, sprite_go); end
    step();
    n_cmp++; if (fwdS_sel !== 2'd0) begin n_bad++; $display("FAIL fl_fwd_clr: got %0d want 0", fwdS_sel); end
    id_idle(); reS = 1; regS_addr = 4; reT = 1; regT_addr = 3; sprite_re = 1; #1;
    n_cmp++; if (stall !== 1'b0 || sprite_go !== 1'b1) begin n_bad++;
      $display("FAIL fl_slot_clr: got stall=%b go=%b want 0/1", stall, sprite_go); end
    step();
    n_cmp++; if (fwdS_sel !== 2'd0 || fwdT_sel !== 2'd2) begin n_bad++;
      $display("FAIL fl_fwd: got %0d/%0d want 0/2", fwdS_sel, fwdT_sel); end
    idle(6);
  endtask

  task automatic test_reset_mid();
    id_idle(); sprite_we = 1; step();
    rst_n = 0; id_idle(); step();
    rst_n = 1; sprite_re = 1; #1;
    n_cmp++; if (sprite_go !== 1'b1) begin n_bad++; $display("FAIL rm_go: got %b want 1", sprite_go); end
    idle(6);
  endtask

  task automatic test_halt();
    id_idle(); sprite_we = 1; step();
    id_idle(); use_dst_reg = 1; dst_reg = 9; step();
    id_idle(); hlt = 1; #1;
    n_cmp++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_bad++;
      $display("FAIL ht_hlt: got stall=%b bubble=%b want 1/1", stall, bubble); end
    step();
    id_idle(); #1;
    n_cmp++; if (stall !== 1'b1 || halted !== 1'b0) begin n_bad++;
      $display("FAIL ht_drain1: got stall=%b halted=%b want 1/0", stall, halted); end
    step();
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL ht_drain2: got %b want 0", halted); end
    step();
    n_cmp++; if (halted !== 1'b1 || stall !== 1'b1) begin n_bad++;
      $display("FAIL ht_halted: got halted=%b stall=%b want 1/1", halted, stall); end
    sprite_re = 1; step(); step(); #1;
    n_cmp++; if (halted !== 1'b1 || sprite_go !== 1'b0) begin n_bad++;
      $display("FAIL ht_sticky: got halted=%b go=%b want 1/0", halted, sprite_go); end
    rst_n = 0; id_idle(); step();
    rst_n = 1; #1;
    n_cmp++; if (halted !== 1'b0 || stall !== 1'b0) begin n_bad++;
      $display("FAIL ht_reset: got halted=%b stall=%b want 0/0", halted, stall); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_sprite_b2b();
    test_io_wait();
    test_flush();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
